// File: rtl/regfile_pkg.sv
// Shared constants and the write-request record for the register-file write queue.
package regfile_pkg;
  localparam int NREGS          = 16;
  localparam int ADDR_W         = 4;
  localparam int DEFAULT_DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]         addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/wq_fifo.sv
// Circular storage for queued register writes: head/tail pointers plus occupancy.
module wq_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  logic [ADDR_W-1:0]                push_addr,
  input  logic [DATA_W-1:0]                push_data,
  output logic [DEPTH-1:0][ADDR_W-1:0]     mem_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]     mem_data,
  output logic [PTR_W-1:0]                 head,
  output logic [CNT_W-1:0]                 count
);
  logic [PTR_W-1:0] tail;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= push_addr;
      mem_data[tail] <= push_data;
    end
  end
endmodule

// File: rtl/regfile_write_queue.sv
// Write queue in front of a 16-entry register file: issues one strobe per entry
// through a 1-of-16 decoder and forwards the youngest pending write to a read port.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ZERO_REG = 0,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              hold,
  input  logic              flush,
  output logic [3:0]        sel,
  output logic              dec_en,
  output logic [DATA_W-1:0] dec_data,
  input  logic [3:0]        rd_addr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_fwd_data,
  output logic [CNT_W-1:0]  count
);
  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic [PTR_W-1:0]             head;
  logic                         push, pop, discard, not_empty;
  logic [PTR_W-1:0]             idx;

  wq_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .head      (head),
    .count     (count)
  );

  // Gating with reset_n keeps ready low while the queue is held in reset.
  assign wr_ready  = reset_n && (count < CNT_W'(DEPTH));
  assign discard   = (ZERO_REG != 0) && (wr_addr == 4'd0);
  assign push      = wr_valid && wr_ready && !flush && !discard;
  assign not_empty = (count != '0);
  assign dec_en    = not_empty && !hold && !flush;
  assign pop       = dec_en;
  assign sel       = not_empty ? mem_addr[head] : 4'd0;
  assign dec_data  = not_empty ? mem_data[head] : '0;

  // Walk oldest to youngest so the most recent matching write wins.
  always_comb begin
    rd_hit      = 1'b0;
    rd_fwd_data = '0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (mem_addr[idx] == rd_addr) &&
          !((ZERO_REG != 0) && (rd_addr == 4'd0))) begin
        rd_hit      = 1'b1;
        rd_fwd_data = mem_data[idx];
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench: a queue-level model tracks pending writes; a monitor pops
// expected strobes whenever the decoder enable fires.
module tb_regfile_write_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_valid = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [3:0]    wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, dec_en, rd_hit;
  logic [3:0]    sel;
  logic [DW-1:0] dec_data, rd_fwd_data;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  wr_req_t mq[$];     // model contents of the queue
  wr_req_t exp_q[$];  // strobes still expected at the decoder

  always #5 clk = ~clk;

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DW), .ZERO_REG(1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .hold(hold), .flush(flush),
    .sel(sel), .dec_en(dec_en), .dec_data(dec_data), .rd_addr(rd_addr),
    .rd_hit(rd_hit), .rd_fwd_data(rd_fwd_data), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics straight from the accept/issue rules.
  always @(posedge clk or negedge reset_n) begin
    bit do_pop, do_push;
    if (!reset_n || flush) begin
      mq.delete();
      exp_q.delete();
    end else begin
      do_pop  = (mq.size() != 0) && !hold;
      do_push = wr_valid && (mq.size() < DEPTH) && (wr_addr != 4'd0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{addr: wr_addr, data: wr_data});
        exp_q.push_back('{addr: wr_addr, data: wr_data});
      end
    end
  end

  // Monitor: checks outputs mid-cycle against the model.
  always @(negedge clk) begin
    int n;
    logic exp_hit;
    logic [DW-1:0] exp_fwd;
    wr_req_t e;
    n = mq.size();
    if (!reset_n) begin
      chk("rst_dec_en", dec_en, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_count", count, 0);
      chk("rst_sel", sel, 0);
      chk("rst_dec_data", dec_data, 0);
      chk("rst_rd_hit", rd_hit, 0);
    end else begin
      chk("count", count, n);
      chk("wr_ready", wr_ready, n < DEPTH);
      chk("dec_en", dec_en, (n != 0) && !hold && !flush);
      if (dec_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe: unexpected strobe sel=%0h data=%0h", sel, dec_data);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_sel", sel, e.addr);
          chk("strobe_data", dec_data, e.data);
        end
      end else if (n == 0) begin
        chk("idle_sel", sel, 0);
        chk("idle_data", dec_data, 0);
      end
      exp_hit = 1'b0;
      exp_fwd = '0;
      foreach (mq[i]) if (mq[i].addr == rd_addr && rd_addr != 4'd0) begin
        exp_hit = 1'b1;
        exp_fwd = mq[i].data;
      end
      chk("rd_hit", rd_hit, exp_hit);
      chk("rd_fwd_data", rd_fwd_data, exp_fwd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    reset_n = 1'b1;
    #1 chk("ready_after_reset", wr_ready, 1);
    cyc();

    // Two back-to-back writes, strobed in order one cycle later.
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5A5A5;
    #1 chk("no_passthru", dec_en, 0);
    cyc();
    chk("first_en", dec_en, 1);
    chk("first_sel", sel, 3);
    chk("first_data", dec_data, 32'hA5A5A5A5);
    wr_addr = 4'd9; wr_data = 32'h12345678;
    cyc();
    wr_valid = 1'b0;
    chk("second_sel", sel, 9);
    chk("second_data", dec_data, 32'h12345678);
    cyc();
    chk("after_two_en", dec_en, 0);

    // Fill under hold, reject a fifth, then drain.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) put(4'(i), $urandom);
    chk("full_count", count, 4);
    chk("full_ready", wr_ready, 0);
    put(4'd12, 32'hDEAD0005);
    chk("fifth_rejected", count, 4);
    hold = 1'b0;
    repeat (5) cyc();
    chk("drained_count", count, 0);

    // Full with pending request: pop first, accept on the next edge.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) put(4'(i + 10), $urandom);
    hold = 1'b0; wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h77;
    cyc();
    chk("full_pop_count", count, 3);
    cyc();
    wr_valid = 1'b0;
    chk("late_accept_count", count, 3);
    repeat (5) cyc();

    // Forwarding: youngest write to the same register wins.
    hold = 1'b1;
    put(4'd5, 32'h1);
    put(4'd5, 32'h2);
    rd_addr = 4'd5;
    #1 chk("fwd_hit", rd_hit, 1);
    chk("fwd_data", rd_fwd_data, 32'h2);
    rd_addr = 4'd6;
    #1 chk("fwd_miss", rd_hit, 0);
    chk("fwd_miss_data", rd_fwd_data, 0);

    // Flush with concurrent write drops everything.
    put(4'd8, 32'h88);
    chk("pre_flush_count", count, 3);
    flush = 1'b1; wr_valid = 1'b1; wr_addr = 4'd4; wr_data = 32'h44;
    cyc();
    flush = 1'b0; wr_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_en", dec_en, 0);

    // Reset in the middle of draining.
    for (int i = 0; i < 3; i++) put(4'(i + 1), $urandom);
    hold = 1'b0;
    cyc();
    reset_n = 1'b0;
    #1 chk("midrst_en", dec_en, 0);
    chk("midrst_count", count, 0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Hard-wired register 0.
    put(4'd0, 32'hFFFF_FFFF);
    chk("zero_count", count, 0);
    chk("zero_en", dec_en, 0);
    rd_addr = 4'd0;
    #1 chk("zero_hit", rd_hit, 0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      wr_valid = ($urandom_range(0, 99) < 60);
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = $urandom;
      hold     = ($urandom_range(0, 99) < 35);
      flush    = ($urandom_range(0, 99) < 4);
      rd_addr  = 4'($urandom_range(0, 15));
      reset_n  = ($urandom_range(0, 199) != 0);
      cyc();
    end
    wr_valid = 1'b0; hold = 1'b0; flush = 1'b0; reset_n = 1'b1;
    repeat (8) cyc();
    chk("final_count", count, 0);
    chk("final_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
